// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini-SRC control path: opcodes, control-word field
// indices, FSM state/step encodings and MDR input-select codes.
// Latency: n/a (definitions only). Backpressure: n/a.
//
// Control word layout (bit index -> datapath strobe); MDRsel occupies 3 bits.
package mini_src_pkg;

   // ---------------- control word ----------------
   localparam int CW_W         = 30;

   localparam int CW_PCOUT     = 0;
   localparam int CW_MARIN     = 1;
   localparam int CW_INCPC     = 2;
   localparam int CW_ZIN       = 3;
   localparam int CW_ZLOWOUT   = 4;
   localparam int CW_PCIN      = 5;
   localparam int CW_MDRIN     = 6;
   localparam int CW_MDRSEL_LO = 7;
   localparam int CW_MDRSEL_HI = 9;
   localparam int CW_MDROUT    = 10;
   localparam int CW_IRIN      = 11;
   localparam int CW_GRA       = 12;
   localparam int CW_GRB       = 13;
   localparam int CW_GRC       = 14;
   localparam int CW_ROUT      = 15;
   localparam int CW_RIN       = 16;
   localparam int CW_YIN       = 17;
   localparam int CW_COUT      = 18;
   localparam int CW_BAOUT     = 19;
   localparam int CW_LOIN      = 20;
   localparam int CW_HIIN      = 21;
   localparam int CW_ZHIGHOUT  = 22;
   localparam int CW_CONIN     = 23;
   localparam int CW_R15IN     = 24;
   localparam int CW_INPORTOUT = 25;
   localparam int CW_OUTPORTIN = 26;
   localparam int CW_HIOUT     = 27;
   localparam int CW_LOOUT     = 28;
   localparam int CW_RAM_WRITE = 29;

   // ---------------- MDR input select ----------------
   localparam logic [2:0] MDR_IDLE    = 3'b000;
   localparam logic [2:0] MDR_BUS     = 3'b001;
   localparam logic [2:0] MDR_RAM     = 3'b010;
   localparam logic [2:0] MDR_MDATAIN = 3'b100;

   // ---------------- opcodes (IR[31:27]) ----------------
   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ANDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01101;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NEG  = 5'b10000;
   localparam logic [4:0] OP_NOT  = 5'b10001;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_JAL  = 5'b10100;
   localparam logic [4:0] OP_IN   = 5'b10101;
   localparam logic [4:0] OP_OUT  = 5'b10110;
   localparam logic [4:0] OP_MFHI = 5'b10111;
   localparam logic [4:0] OP_MFLO = 5'b11000;
   localparam logic [4:0] OP_NOP  = 5'b11001;
   localparam logic [4:0] OP_HALT = 5'b11010;

   // ---------------- FSM encodings ----------------
   localparam int T_MAX = 7;

   localparam logic [2:0] T0 = 3'd0;
   localparam logic [2:0] T1 = 3'd1;
   localparam logic [2:0] T2 = 3'd2;
   localparam logic [2:0] T3 = 3'd3;
   localparam logic [2:0] T4 = 3'd4;
   localparam logic [2:0] T5 = 3'd5;
   localparam logic [2:0] T6 = 3'd6;
   localparam logic [2:0] T7 = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_HALT = 2'd2
   } state_t;

   // Immediate-form ALU ops take the second operand from C instead of Rc.
   function automatic logic op_is_imm(input logic [4:0] op);
      return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
   endfunction

endpackage

// File: rtl/control_step_decoder.sv
// Purpose: combinational decode of {step, opcode, con_ff} into the control word.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports:
//   i_step      in   3     current T-step
//   i_opcode    in   5     IR opcode (ignored during T0-T2)
//   i_con_ff    in   1     branch condition, used only at br T6
//   o_ctrl      out  CW_W  control word for this step
//   o_last_step out  1     this step is the last of the instruction -> T0 next
//   o_go_halt   out  1     halt instruction decoded -> HALT next
//   o_illegal   out  1     unknown opcode decoded (treated as nop)
module control_step_decoder
   import mini_src_pkg::*;
(
   input  logic [2:0]      i_step,
   input  logic [4:0]      i_opcode,
   input  logic            i_con_ff,
   output logic [CW_W-1:0] o_ctrl,
   output logic            o_last_step,
   output logic            o_go_halt,
   output logic            o_illegal
);

   logic w_imm;

   assign w_imm = op_is_imm(i_opcode);

   always_comb begin
      o_ctrl      = '0;
      o_last_step = 1'b0;
      o_go_halt   = 1'b0;
      o_illegal   = 1'b0;

      // Fetch is common to every instruction; the opcode is not yet loaded.
      if (i_step == T0) begin
         o_ctrl[CW_PCOUT] = 1'b1; o_ctrl[CW_MARIN] = 1'b1;
         o_ctrl[CW_INCPC] = 1'b1; o_ctrl[CW_ZIN]   = 1'b1;
      end else if (i_step == T1) begin
         o_ctrl[CW_ZLOWOUT] = 1'b1; o_ctrl[CW_PCIN] = 1'b1;
         o_ctrl[CW_MDRSEL_HI:CW_MDRSEL_LO] = MDR_RAM;
         o_ctrl[CW_MDRIN] = 1'b1;
      end else if (i_step == T2) begin
         o_ctrl[CW_MDROUT] = 1'b1; o_ctrl[CW_IRIN] = 1'b1;
      end else begin
         // Any step an instruction never reaches falls into a default arm that
         // asserts last_step, so the counter can never run past T7.
         case (i_opcode)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
            OP_ADDI, OP_ANDI, OP_ORI: begin
               case (i_step)
                  T3: begin
                     o_ctrl[CW_GRB] = 1'b1; o_ctrl[CW_ROUT] = 1'b1; o_ctrl[CW_YIN] = 1'b1;
                  end
                  T4: begin
                     if (w_imm) begin
                        o_ctrl[CW_COUT] = 1'b1;
                     end else begin
                        o_ctrl[CW_GRC] = 1'b1; o_ctrl[CW_ROUT] = 1'b1;
                     end
                     o_ctrl[CW_ZIN] = 1'b1;
                  end
                  T5: begin
                     o_ctrl[CW_ZLOWOUT] = 1'b1; o_ctrl[CW_GRA] = 1'b1; o_ctrl[CW_RIN] = 1'b1;
                     o_last_step = 1'b1;
                  end
                  default: o_last_step = 1'b1;
               endcase
            end

            OP_MUL, OP_DIV: begin
               case (i_step)
                  T3: begin
                     o_ctrl[CW_GRA] = 1'b1; o_ctrl[CW_ROUT] = 1'b1; o_ctrl[CW_YIN] = 1'b1;
                  end
                  T4: begin
                     o_ctrl[CW_GRB] = 1'b1; o_ctrl[CW_ROUT] = 1'b1; o_ctrl[CW_ZIN] = 1'b1;
                  end
                  T5: begin
                     o_ctrl[CW_ZLOWOUT] = 1'b1; o_ctrl[CW_LOIN] = 1'b1;
                  end
                  T6: begin
                     o_ctrl[CW_ZHIGHOUT] = 1'b1; o_ctrl[CW_HIIN] = 1'b1;
                     o_last_step = 1'b1;
                  end
                  default: o_last_step = 1'b1;
               endcase
            end

            OP_NEG, OP_NOT: begin
               case (i_step)
                  T3: begin
                     o_ctrl[CW_GRB] = 1'b1; o_ctrl[CW_ROUT] = 1'b1; o_ctrl[CW_ZIN] = 1'b1;
                  end
                  T4: begin
                     o_ctrl[CW_ZLOWOUT] = 1'b1; o_ctrl[CW_GRA] = 1'b1; o_ctrl[CW_RIN] = 1'b1;
                     o_last_step = 1'b1;
                  end
                  default: o_last_step = 1'b1;
               endcase
            end

            // Effective address = (Rb or 0 when Rb=R0) + C, via BAout.
            OP_LD, OP_LDI, OP_ST: begin
               case (i_step)
                  T3: begin
                     o_ctrl[CW_GRB] = 1'b1; o_ctrl[CW_BAOUT] = 1'b1;
                     o_ctrl[CW_ROUT] = 1'b1; o_ctrl[CW_YIN] = 1'b1;
                  end
                  T4: begin
                     o_ctrl[CW_COUT] = 1'b1; o_ctrl[CW_ZIN] = 1'b1;
                  end
                  T5: begin
                     o_ctrl[CW_ZLOWOUT] = 1'b1;
                     if (i_opcode == OP_LDI) begin
                        o_ctrl[CW_GRA] = 1'b1; o_ctrl[CW_RIN] = 1'b1;
                        o_last_step = 1'b1;
                     end else begin
                        o_ctrl[CW_MARIN] = 1'b1;
                     end
                  end
                  T6: begin
                     if (i_opcode == OP_LD) begin
                        o_ctrl[CW_MDRSEL_HI:CW_MDRSEL_LO] = MDR_RAM;
                        o_ctrl[CW_MDRIN] = 1'b1;
                     end else if (i_opcode == OP_ST) begin
                        o_ctrl[CW_GRA] = 1'b1; o_ctrl[CW_ROUT] = 1'b1;
                        o_ctrl[CW_MDRSEL_HI:CW_MDRSEL_LO] = MDR_BUS;
                        o_ctrl[CW_MDRIN] = 1'b1;
                     end else begin
                        o_last_step = 1'b1;
                     end
                  end
                  T7: begin
                     if (i_opcode == OP_LD) begin
                        o_ctrl[CW_MDROUT] = 1'b1; o_ctrl[CW_GRA] = 1'b1; o_ctrl[CW_RIN] = 1'b1;
                     end else if (i_opcode == OP_ST) begin
                        o_ctrl[CW_RAM_WRITE] = 1'b1;
                     end
                     o_last_step = 1'b1;
                  end
                  default: o_last_step = 1'b1;
               endcase
            end

            OP_BR: begin
               case (i_step)
                  T3: begin
                     o_ctrl[CW_GRA] = 1'b1; o_ctrl[CW_ROUT] = 1'b1; o_ctrl[CW_CONIN] = 1'b1;
                  end
                  T4: begin
                     o_ctrl[CW_PCOUT] = 1'b1; o_ctrl[CW_YIN] = 1'b1;
                  end
                  T5: begin
                     o_ctrl[CW_COUT] = 1'b1; o_ctrl[CW_ZIN] = 1'b1;
                  end
                  T6: begin
                     // Not-taken branch still spends T6, with an idle word.
                     if (i_con_ff) begin
                        o_ctrl[CW_ZLOWOUT] = 1'b1; o_ctrl[CW_PCIN] = 1'b1;
                     end
                     o_last_step = 1'b1;
                  end
                  default: o_last_step = 1'b1;
               endcase
            end

            OP_JR: begin
               if (i_step == T3) begin
                  o_ctrl[CW_GRA] = 1'b1; o_ctrl[CW_ROUT] = 1'b1; o_ctrl[CW_PCIN] = 1'b1;
               end
               o_last_step = 1'b1;
            end

            OP_JAL: begin
               if (i_step == T3) begin
                  o_ctrl[CW_PCOUT] = 1'b1; o_ctrl[CW_R15IN] = 1'b1;
               end else begin
                  o_ctrl[CW_GRA] = 1'b1; o_ctrl[CW_ROUT] = 1'b1; o_ctrl[CW_PCIN] = 1'b1;
                  o_last_step = 1'b1;
               end
            end

            OP_IN: begin
               if (i_step == T3) begin
                  o_ctrl[CW_INPORTOUT] = 1'b1; o_ctrl[CW_GRA] = 1'b1; o_ctrl[CW_RIN] = 1'b1;
               end
               o_last_step = 1'b1;
            end

            OP_OUT: begin
               if (i_step == T3) begin
                  o_ctrl[CW_GRA] = 1'b1; o_ctrl[CW_ROUT] = 1'b1; o_ctrl[CW_OUTPORTIN] = 1'b1;
               end
               o_last_step = 1'b1;
            end

            OP_MFHI, OP_MFLO: begin
               if (i_step == T3) begin
                  o_ctrl[CW_HIOUT] = (i_opcode == OP_MFHI);
                  o_ctrl[CW_LOOUT] = (i_opcode == OP_MFLO);
                  o_ctrl[CW_GRA]   = 1'b1; o_ctrl[CW_RIN] = 1'b1;
               end
               o_last_step = 1'b1;
            end

            OP_NOP: o_last_step = 1'b1;

            OP_HALT: o_go_halt = 1'b1;

            // Unknown opcode: nop timing, flagged to the sticky bad_op.
            default: begin
               o_illegal   = 1'b1;
               o_last_step = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/control_unit.sv
// Purpose: Mini-SRC multi-cycle control FSM (IDLE / EXEC T0..T7 / HALT).
// Latency: ctrl is a Moore decode of the registered state, valid the cycle the step is entered.
// Backpressure: none; the datapath must accept one control word per cycle.
// Ports:
//   clk     in   1     clock
//   clr     in   1     synchronous active-high reset -> IDLE, T0, bad_op cleared
//   start   in   1     level; leaves IDLE when sampled high
//   opcode  in   5     IR[31:27], only meaningful from T3
//   con_ff  in   1     CON flip-flop (branch condition)
//   ctrl    out  CW_W  control word, zero outside EXEC
//   run     out  1     in EXEC
//   halted  out  1     in HALT
//   bad_op  out  1     sticky unknown-opcode flag
module control_unit
   import mini_src_pkg::*;
(
   input  logic            clk,
   input  logic            clr,
   input  logic            start,
   input  logic [4:0]      opcode,
   input  logic            con_ff,
   output logic [CW_W-1:0] ctrl,
   output logic            run,
   output logic            halted,
   output logic            bad_op
);

   state_t     r_state;
   logic [2:0] r_step;
   logic       r_bad_op;
   logic       r_run;
   logic       r_halted;

   logic [CW_W-1:0] w_ctrl;
   logic            w_last_step;
   logic            w_go_halt;
   logic            w_illegal;

   control_step_decoder u_dec (
      .i_step      (r_step),
      .i_opcode    (opcode),
      .i_con_ff    (con_ff),
      .o_ctrl      (w_ctrl),
      .o_last_step (w_last_step),
      .o_go_halt   (w_go_halt),
      .o_illegal   (w_illegal)
   );

   // In IDLE the step sits at T0, which would decode to the fetch word; gate it.
   assign ctrl   = (r_state == S_EXEC) ? w_ctrl : '0;
   assign run    = r_run;
   assign halted = r_halted;
   assign bad_op = r_bad_op;

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state  <= S_IDLE;
         r_step   <= T0;
         r_bad_op <= 1'b0;
         r_run    <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_EXEC;
                  r_step  <= T0;
                  r_run   <= 1'b1;
               end
            end

            S_EXEC: begin
               if (w_illegal) begin
                  r_bad_op <= 1'b1;
               end
               if (w_go_halt) begin
                  r_state  <= S_HALT;
                  r_step   <= T0;
                  r_run    <= 1'b0;
                  r_halted <= 1'b1;
               end else if (w_last_step) begin
                  r_step <= T0;
               end else begin
                  r_step <= r_step + 3'd1;
               end
            end

            // Only clr leaves HALT.
            S_HALT: r_state <= S_HALT;

            default: begin
               r_state  <= S_IDLE;
               r_step   <= T0;
               r_run    <= 1'b0;
               r_halted <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each task drives one scenario and checks
// the control word, run/halted/bad_op and single-bus-source per cycle.
module tb_control_unit;
   import mini_src_pkg::*;

   logic            clk = 1'b0;
   logic            clr, start, con_ff;
   logic [4:0]      opcode;
   logic [CW_W-1:0] ctrl;
   logic            run, halted, bad_op;

   int checks = 0;
   int errors = 0;

   logic [CW_W-1:0] cap    [0:8];
   logic            runcap [0:8];
   logic [CW_W-1:0] e_t0, e_t1, e_t2;

   always #5 clk = ~clk;

   control_unit dut (
      .clk    (clk),
      .clr    (clr),
      .start  (start),
      .opcode (opcode),
      .con_ff (con_ff),
      .ctrl   (ctrl),
      .run    (run),
      .halted (halted),
      .bad_op (bad_op)
   );

   function automatic logic [CW_W-1:0] b(input int i);
      logic [CW_W-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [CW_W-1:0] mdr(input logic [2:0] s);
      logic [CW_W-1:0] v;
      v = '0;
      v[CW_MDRSEL_LO +: 3] = s;
      return v;
   endfunction

   // Bus drivers; BAout only qualifies Rout so it is not a separate source.
   function automatic int bus_cnt(input logic [CW_W-1:0] w);
      int n;
      n = 0;
      if (w[CW_PCOUT])     n++;
      if (w[CW_ZLOWOUT])   n++;
      if (w[CW_ZHIGHOUT])  n++;
      if (w[CW_MDROUT])    n++;
      if (w[CW_ROUT])      n++;
      if (w[CW_COUT])      n++;
      if (w[CW_INPORTOUT]) n++;
      if (w[CW_HIOUT])     n++;
      if (w[CW_LOOUT])     n++;
      return n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction from T0, capturing ctrl/run for steps 0..n-1 and
   // the following cycle (index n). A garbage opcode is presented during fetch.
   task automatic run_op(input logic [4:0] op, input logic con, input int n);
      con_ff = con;
      opcode = OP_HALT;
      for (int i = 0; i <= n; i++) begin
         #1;
         cap[i]    = ctrl;
         runcap[i] = run;
         if (i == 2) opcode = op;
         if (i < n) tick();
      end
   endtask

   task automatic test_reset();
      clr = 1'b1; start = 1'b0; opcode = OP_NOP; con_ff = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (i == 0) start = 1'b1;
         #1;
         checks++;
         if (ctrl !== '0) begin errors++; $display("FAIL reset_ctrl cyc%0d got %h want 0", i, ctrl); end
         checks++;
         if (run !== 1'b0) begin errors++; $display("FAIL reset_run cyc%0d got %b want 0", i, run); end
         checks++;
         if (halted !== 1'b0 || bad_op !== 1'b0) begin
            errors++; $display("FAIL reset_flags cyc%0d got halted=%b bad_op=%b want 0 0", i, halted, bad_op);
         end
      end
      clr = 1'b0;
      tick();
      #1;
      checks++;
      if (ctrl !== e_t0) begin errors++; $display("FAIL first_t0 got %h want %h", ctrl, e_t0); end
      checks++;
      if (run !== 1'b1) begin errors++; $display("FAIL first_run got %b want 1", run); end
   endtask

   task automatic test_add();
      logic [CW_W-1:0] exp [0:6];
      exp[0] = e_t0; exp[1] = e_t1; exp[2] = e_t2;
      exp[3] = b(CW_GRB) | b(CW_ROUT) | b(CW_YIN);
      exp[4] = b(CW_GRC) | b(CW_ROUT) | b(CW_ZIN);
      exp[5] = b(CW_ZLOWOUT) | b(CW_GRA) | b(CW_RIN);
      exp[6] = e_t0;
      run_op(OP_ADD, 1'b0, 6);
      for (int i = 0; i <= 6; i++) begin
         checks++;
         if (cap[i] !== exp[i]) begin errors++; $display("FAIL add_T%0d got %h want %h", i, cap[i], exp[i]); end
         checks++;
         if (bus_cnt(cap[i]) > 1) begin errors++; $display("FAIL add_bus T%0d got %0d sources want <=1", i, bus_cnt(cap[i])); end
         checks++;
         if (runcap[i] !== 1'b1) begin errors++; $display("FAIL add_run T%0d got %b want 1", i, runcap[i]); end
      end
   endtask

   task automatic test_branch();
      logic [CW_W-1:0] exp [0:7];
      for (int c = 0; c < 2; c++) begin
         exp[0] = e_t0; exp[1] = e_t1; exp[2] = e_t2;
         exp[3] = b(CW_GRA) | b(CW_ROUT) | b(CW_CONIN);
         exp[4] = b(CW_PCOUT) | b(CW_YIN);
         exp[5] = b(CW_COUT) | b(CW_ZIN);
         exp[6] = (c == 1) ? (b(CW_ZLOWOUT) | b(CW_PCIN)) : '0;
         exp[7] = e_t0;
         run_op(OP_BR, (c == 1), 7);
         for (int i = 0; i <= 7; i++) begin
            checks++;
            if (cap[i] !== exp[i]) begin errors++; $display("FAIL br_con%0d_T%0d got %h want %h", c, i, cap[i], exp[i]); end
            checks++;
            if (bus_cnt(cap[i]) > 1) begin errors++; $display("FAIL br_bus T%0d got %0d sources want <=1", i, bus_cnt(cap[i])); end
         end
      end
   endtask

   task automatic test_ld_st();
      logic [CW_W-1:0] exp [0:8];
      for (int k = 0; k < 2; k++) begin
         exp[3] = b(CW_GRB) | b(CW_BAOUT) | b(CW_ROUT) | b(CW_YIN);
         exp[4] = b(CW_COUT) | b(CW_ZIN);
         exp[5] = b(CW_ZLOWOUT) | b(CW_MARIN);
         if (k == 0) begin
            exp[6] = b(CW_GRA) | b(CW_ROUT) | mdr(3'b001) | b(CW_MDRIN);
            exp[7] = b(CW_RAM_WRITE);
         end else begin
            exp[6] = mdr(3'b010) | b(CW_MDRIN);
            exp[7] = b(CW_MDROUT) | b(CW_GRA) | b(CW_RIN);
         end
         exp[8] = e_t0;
         run_op((k == 0) ? OP_ST : OP_LD, 1'b0, 8);
         for (int i = 3; i <= 8; i++) begin
            checks++;
            if (cap[i] !== exp[i]) begin
               errors++; $display("FAIL %s_T%0d got %h want %h", (k == 0) ? "st" : "ld", i, cap[i], exp[i]);
            end
            checks++;
            if (bus_cnt(cap[i]) > 1) begin errors++; $display("FAIL ldst_bus T%0d got %0d sources want <=1", i, bus_cnt(cap[i])); end
         end
      end
   endtask

   task automatic test_misc_ops();
      logic [4:0]      ops [0:3];
      int              ns  [0:3];
      logic [CW_W-1:0] ex  [0:3][3:7];
      ops[0] = OP_MUL;  ns[0] = 4;
      ex[0][3] = b(CW_GRA) | b(CW_ROUT) | b(CW_YIN);
      ex[0][4] = b(CW_GRB) | b(CW_ROUT) | b(CW_ZIN);
      ex[0][5] = b(CW_ZLOWOUT) | b(CW_LOIN);
      ex[0][6] = b(CW_ZHIGHOUT) | b(CW_HIIN);
      ex[0][7] = e_t0;
      ops[1] = OP_ADDI; ns[1] = 3;
      ex[1][3] = b(CW_GRB) | b(CW_ROUT) | b(CW_YIN);
      ex[1][4] = b(CW_COUT) | b(CW_ZIN);
      ex[1][5] = b(CW_ZLOWOUT) | b(CW_GRA) | b(CW_RIN);
      ex[1][6] = e_t0; ex[1][7] = '0;
      ops[2] = OP_JAL;  ns[2] = 2;
      ex[2][3] = b(CW_PCOUT) | b(CW_R15IN);
      ex[2][4] = b(CW_GRA) | b(CW_ROUT) | b(CW_PCIN);
      ex[2][5] = e_t0; ex[2][6] = '0; ex[2][7] = '0;
      ops[3] = OP_NEG;  ns[3] = 2;
      ex[3][3] = b(CW_GRB) | b(CW_ROUT) | b(CW_ZIN);
      ex[3][4] = b(CW_ZLOWOUT) | b(CW_GRA) | b(CW_RIN);
      ex[3][5] = e_t0; ex[3][6] = '0; ex[3][7] = '0;
      for (int k = 0; k < 4; k++) begin
         run_op(ops[k], 1'b0, 3 + ns[k]);
         for (int i = 3; i <= 3 + ns[k]; i++) begin
            checks++;
            if (cap[i] !== ex[k][i]) begin
               errors++; $display("FAIL op%b_T%0d got %h want %h", ops[k], i, cap[i], ex[k][i]);
            end
         end
      end
   endtask

   task automatic test_bad_op();
      checks++;
      if (bad_op !== 1'b0) begin errors++; $display("FAIL bad_op_pre got %b want 0", bad_op); end
      run_op(5'b11111, 1'b0, 4);
      checks++;
      if (cap[3] !== '0) begin errors++; $display("FAIL unk_T3 got %h want 0", cap[3]); end
      checks++;
      if (cap[4] !== e_t0) begin errors++; $display("FAIL unk_next got %h want %h", cap[4], e_t0); end
      checks++;
      if (bad_op !== 1'b1) begin errors++; $display("FAIL bad_op_set got %b want 1", bad_op); end
      run_op(OP_NOP, 1'b0, 4);
      checks++;
      if (cap[3] !== '0 || cap[4] !== e_t0) begin
         errors++; $display("FAIL nop got T3=%h T0=%h want 0 %h", cap[3], cap[4], e_t0);
      end
      checks++;
      if (bad_op !== 1'b1) begin errors++; $display("FAIL bad_op_sticky got %b want 1", bad_op); end
   endtask

   task automatic test_clr_mid();
      opcode = OP_HALT;
      tick(); tick();
      opcode = OP_LD;
      tick(); tick(); tick();
      #1;
      checks++;
      if (ctrl !== (b(CW_ZLOWOUT) | b(CW_MARIN))) begin
         errors++; $display("FAIL ld_T5 got %h want %h", ctrl, b(CW_ZLOWOUT) | b(CW_MARIN));
      end
      clr = 1'b1;
      tick();
      #1;
      checks++;
      if (ctrl !== '0 || run !== 1'b0 || halted !== 1'b0) begin
         errors++; $display("FAIL clr_mid got ctrl=%h run=%b halted=%b want 0 0 0", ctrl, run, halted);
      end
      checks++;
      if (bad_op !== 1'b0) begin errors++; $display("FAIL clr_bad_op got %b want 0", bad_op); end
      clr = 1'b0; start = 1'b0;
      tick(); tick();
      #1;
      checks++;
      if (run !== 1'b0 || ctrl !== '0) begin errors++; $display("FAIL idle_hold got run=%b ctrl=%h want 0 0", run, ctrl); end
      start = 1'b1;
      tick();
      #1;
      checks++;
      if (ctrl !== e_t0 || run !== 1'b1) begin
         errors++; $display("FAIL restart got ctrl=%h run=%b want %h 1", ctrl, run, e_t0);
      end
   endtask

   task automatic test_halt();
      opcode = OP_NOP;
      tick(); tick();
      opcode = OP_HALT;
      tick();
      #1;
      checks++;
      if (ctrl !== '0 || run !== 1'b1) begin
         errors++; $display("FAIL halt_T3 got ctrl=%h run=%b want 0 1", ctrl, run);
      end
      start = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) begin
         #1;
         checks++;
         if (halted !== 1'b1) begin errors++; $display("FAIL halted cyc%0d got %b want 1", i, halted); end
         checks++;
         if (run !== 1'b0) begin errors++; $display("FAIL halt_run cyc%0d got %b want 0", i, run); end
         checks++;
         if (ctrl !== '0) begin errors++; $display("FAIL halt_ctrl cyc%0d got %h want 0", i, ctrl); end
         tick();
      end
      clr = 1'b1; start = 1'b0;
      tick();
      clr = 1'b0;
      #1;
      checks++;
      if (halted !== 1'b0 || run !== 1'b0 || ctrl !== '0) begin
         errors++; $display("FAIL halt_clr got halted=%b run=%b ctrl=%h want 0 0 0", halted, run, ctrl);
      end
   endtask

   initial begin
      e_t0 = b(CW_PCOUT) | b(CW_MARIN) | b(CW_INCPC) | b(CW_ZIN);
      e_t1 = b(CW_ZLOWOUT) | b(CW_PCIN) | mdr(3'b010) | b(CW_MDRIN);
      e_t2 = b(CW_MDROUT) | b(CW_IRIN);
      test_reset();
      test_add();
      test_branch();
      test_ld_st();
      test_misc_ops();
      test_bad_op();
      test_clr_mid();
      test_halt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

endmodule
